// File: rtl/frame_buf_reader_if.sv
// Frame buffer read port plus the pixel stream port of the frame buffer reader.
// The master modport is the reader side; the slave modport is the buffer/sink side.
interface frame_buf_reader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 19
) ();
    logic                  rd_en_out;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data_in;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_sof;
    logic                  pix_eol;

    modport master (
        output rd_en_out,
        output rd_addr,
        input  rd_data_in,
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output pix_sof,
        output pix_eol
    );

    modport slave (
        input  rd_en_out,
        input  rd_addr,
        output rd_data_in,
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  pix_sof,
        input  pix_eol
    );
endinterface

// File: rtl/frame_buf_reader.sv
// Frame buffer read controller: walks one frame of addresses per start pulse,
// hides the buffer read latency behind a credit-limited show-ahead FIFO and
// emits pixels as a valid/ready stream with start-of-frame / end-of-line flags.
module frame_buf_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FRAME_BASE = 0,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    frame_buf_reader_if.master  bus,
    output logic                busy,
    output logic                frame_done
);
    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [CNT_W-1:0]      issue_cnt;
    logic [RD_LATENCY-1:0] pipe;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [PTR_W:0]        fifo_count;

    logic [X_W-1:0]        ox;
    logic [Y_W-1:0]        oy;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  valid_w;
    logic                  last_issue;
    logic                  last_pix;
    int unsigned           in_flight;
    int unsigned           occupancy;

    assign valid_w    = (fifo_count != '0);
    assign push       = pipe[RD_LATENCY-1];
    assign pop        = valid_w & bus.pix_ready;
    assign last_issue = issue && (issue_cnt == CNT_W'(TOTAL - 1));
    assign last_pix   = (ox == X_W'(H_ACTIVE - 1)) && (oy == Y_W'(V_ACTIVE - 1));
    assign issue      = (state == FETCH) && (occupancy < FIFO_DEPTH);

    assign bus.rd_en_out = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.pix_valid = valid_w;
    assign bus.pix_data  = valid_w ? mem[rptr] : '0;
    assign bus.pix_sof   = valid_w && (ox == '0) && (oy == '0);
    assign bus.pix_eol   = valid_w && (ox == X_W'(H_ACTIVE - 1));

    // Credit accounting: pending request, reads in the latency pipe and FIFO
    // entries; the slot freed by a same-edge pop is reusable, which keeps the
    // stream bubble-free at full rate without ever exceeding the FIFO.
    always_comb begin
        in_flight = {31'd0, ~rd_en_q};
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + {31'd0, pipe[i]};
        end
        occupancy = in_flight + 32'(fifo_count) - {31'd0, pop};
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (pop && last_pix) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Registered read request towards the buffer and the issue counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            issue_cnt <= '0;
        end else begin
            rd_en_q <= ~issue;
            if (issue) begin
                rd_addr_q <= ADDR_WIDTH'(FRAME_BASE) + ADDR_WIDTH'(issue_cnt);
            end
            if (state == IDLE)  issue_cnt <= '0;
            else if (issue)     issue_cnt <= issue_cnt + 1'b1;
        end
    end

    // Latency pipe: a bit enters when the buffer samples a request and
    // marks the edge at which its data is captured when it emerges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= ~rd_en_q;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // FIFO storage, no reset needed since reads are masked by valid
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.rd_data_in;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output position counters and end-of-frame pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ox         <= '0;
            oy         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && last_pix && (state == DRAIN);
            if (pop) begin
                if (ox == X_W'(H_ACTIVE - 1)) begin
                    ox <= '0;
                    oy <= (oy == Y_W'(V_ACTIVE - 1)) ? '0 : oy + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_buf_reader.sv
// Directed bench for frame_buf_reader on a 4x2 frame at base 0x10 with a
// buffer model that returns data equal to the sampled address.
module tb_frame_buf_reader;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 19;
    localparam int unsigned H     = 4;
    localparam int unsigned V     = 2;
    localparam int unsigned BASE  = 32'h10;
    localparam int unsigned RDL   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int          NPIX  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    int errors = 0;
    int checks = 0;

    frame_buf_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    frame_buf_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_ACTIVE(H), .V_ACTIVE(V),
        .FRAME_BASE(BASE), .RD_LATENCY(RDL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Buffer model: samples a read at the edge, data valid RD_LATENCY edges later
    logic [DW-1:0] buf_s0 = '0;
    logic [DW-1:0] buf_s1 = '0;
    always @(posedge clk) begin
        buf_s0 <= !bus.rd_en_out ? DW'(bus.rd_addr) : 32'hDEAD_BEEF;
        buf_s1 <= buf_s0;
    end
    assign bus.rd_data_in = buf_s1;

    // Monitor state, sampled on the falling edge
    logic [31:0] rd_log[$];
    logic [31:0] pix_log[$];
    logic        sof_log[$];
    logic        eol_log[$];
    int cyc = 0;
    int issued, xfer, done_cnt, busy_fall, max_occ, stall_bad, stall_seen;
    int rd_first_cyc, rd_last_cyc, pix_first_cyc, pix_last_cyc, done_cyc;
    logic        prev_busy = 1'b0;
    logic        stalled   = 1'b0;
    logic [31:0] st_data;
    logic        st_sof, st_eol;

    // Log reads, transfers, pulses and stall stability
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_busy = 1'b0;
            stalled   = 1'b0;
        end else begin
            if (!bus.rd_en_out) begin
                if (rd_log.size() == 0) rd_first_cyc = cyc;
                rd_last_cyc = cyc;
                rd_log.push_back(32'(bus.rd_addr));
                issued++;
            end
            if (stalled && (!bus.pix_valid || bus.pix_data != st_data ||
                            bus.pix_sof != st_sof || bus.pix_eol != st_eol))
                stall_bad++;
            if (bus.pix_valid && bus.pix_ready) begin
                if (pix_log.size() == 0) pix_first_cyc = cyc;
                pix_last_cyc = cyc;
                pix_log.push_back(bus.pix_data);
                sof_log.push_back(bus.pix_sof);
                eol_log.push_back(bus.pix_eol);
                xfer++;
            end
            stalled = bus.pix_valid && !bus.pix_ready;
            if (stalled) stall_seen++;
            st_data = bus.pix_data;
            st_sof  = bus.pix_sof;
            st_eol  = bus.pix_eol;
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall++;
            prev_busy = busy;
            if (issued - xfer > max_occ) max_occ = issued - xfer;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        pix_log.delete();
        sof_log.delete();
        eol_log.delete();
        issued = 0; xfer = 0; done_cnt = 0; busy_fall = 0; max_occ = 0;
        stall_bad = 0; stall_seen = 0;
        rd_first_cyc = 0; rd_last_cyc = 0; pix_first_cyc = 0; pix_last_cyc = 0; done_cyc = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
        repeat (4) tick();
    endtask

    task automatic wait_pix(input string tag);
        int n = 0;
        while (pix_log.size() < NPIX && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_pix_seen"}, 32'(pix_log.size() >= NPIX), 1);
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_nrd"}, 32'(rd_log.size()), NPIX);
        check({tag, "_npix"}, 32'(pix_log.size()), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (i < rd_log.size())
                check($sformatf("%s_addr%0d", tag, i), rd_log[i], BASE + 32'(i));
            if (i < pix_log.size()) begin
                check($sformatf("%s_data%0d", tag, i), pix_log[i], BASE + 32'(i));
                check($sformatf("%s_sof%0d", tag, i), 32'(sof_log[i]), 32'(i == 0));
                check($sformatf("%s_eol%0d", tag, i), 32'(eol_log[i]), 32'((i % H) == H - 1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low_seen;
        bus.pix_ready = 1'b0;
        clear_logs();

        // Reset held with random inputs
        low_seen = 0;
        for (int i = 0; i < 12; i++) begin
            start         = 1'($urandom_range(0, 1));
            bus.pix_ready = 1'($urandom_range(0, 1));
            tick();
            if (!bus.rd_en_out) low_seen++;
        end
        check("rst_rd_en_low_seen", 32'(low_seen), 0);
        check("rst_rd_en", 32'(bus.rd_en_out), 1);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_pix_data", bus.pix_data, 0);
        check("rst_pix_valid", 32'(bus.pix_valid), 0);
        check("rst_pix_sof", 32'(bus.pix_sof), 0);
        check("rst_pix_eol", 32'(bus.pix_eol), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        start = 1'b0;
        bus.pix_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();

        // Full rate frame
        clear_logs();
        pulse_start();
        n = 0;
        while (!bus.pix_valid && n < 20) begin
            tick();
            n++;
        end
        check("full_start_to_valid", 32'(n), RDL + 2);
        wait_done("full");
        check_frame("full");
        check("full_rd_contig", 32'(rd_last_cyc - rd_first_cyc), NPIX - 1);
        check("full_pix_contig", 32'(pix_last_cyc - pix_first_cyc), NPIX - 1);
        check("full_done_after_last", 32'(done_cyc - pix_last_cyc), 1);
        check("full_done_cnt", 32'(done_cnt), 1);
        check("full_busy_idle", 32'(busy), 0);

        // Backpressure after the first transfer
        clear_logs();
        pulse_start();
        n = 0;
        while (xfer < 1 && n < 50) begin
            tick();
            n++;
        end
        bus.pix_ready = 1'b0;
        repeat (6) tick();
        bus.pix_ready = 1'b1;
        wait_done("bp");
        check_frame("bp");
        check("bp_max_outstanding", 32'(max_occ <= DEPTH), 1);
        check("bp_stall_seen", 32'(stall_seen >= 6), 1);
        check("bp_stall_stable", 32'(stall_bad), 0);
        check("bp_rd_gap", 32'((rd_last_cyc - rd_first_cyc) > NPIX - 1), 1);
        check("bp_done_cnt", 32'(done_cnt), 1);

        // Start pulses during FETCH and DRAIN are ignored
        clear_logs();
        pulse_start();
        tick();
        tick();
        check("ign_in_fetch_busy", 32'(busy), 1);
        pulse_start();
        n = 0;
        while (issued < NPIX && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("ign_in_drain_busy", 32'(busy), 1);
        pulse_start();
        wait_done("ign");
        repeat (10) tick();
        check("ign_reads", 32'(issued), NPIX);
        check("ign_done_cnt", 32'(done_cnt), 1);
        check("ign_busy_fall", 32'(busy_fall), 1);
        check("ign_idle", 32'(busy), 0);

        // Reset in the middle of a frame
        clear_logs();
        pulse_start();
        n = 0;
        while (issued < 3 && n < 50) begin
            tick();
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(bus.rd_en_out), 1);
        check("mid_rst_valid", 32'(bus.pix_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_addr", 32'(bus.rd_addr), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        pulse_start();
        wait_done("mid");
        check_frame("mid");
        check("mid_done_cnt", 32'(done_cnt), 1);

        // Back-to-back frames, start on the frame_done cycle
        clear_logs();
        pulse_start();
        n = 0;
        while (!frame_done && n < 100) begin
            tick();
            n++;
        end
        check("b2b_first_done", 32'(frame_done), 1);
        check_frame("b2b1");
        start = 1'b1;
        clear_logs();
        tick();
        start = 1'b0;
        check("b2b_restart_busy", 32'(busy), 1);
        wait_pix("b2b2");
        check_frame("b2b2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
